// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
// Modes are packed as {cpol, cpha}.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Host-side request/response bundle of the SPI shift engine.
// The controller uses master, the engine uses slave.
interface spi_shift_engine_if #(
  parameter int N     = 16,
  parameter int DIV_W = 8
);

  logic             start;
  logic [N-1:0]     dataSe;
  logic             cpol;
  logic             cpha;
  logic             lsb_first;
  logic [DIV_W-1:0] clk_div;
  logic             busy;
  logic             done;
  logic [N-1:0]     dataRe;

  modport master (
    output start, dataSe, cpol, cpha,
    output lsb_first, clk_div,
    input  busy, done, dataRe
  );

  modport slave (
    input  start, dataSe, cpol, cpha,
    input  lsb_first, clk_div,
    output busy, done, dataRe
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: one-cycle tick every div+1 cycles while enabled.
// Restarts from zero whenever enable drops.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    tick  = en && (cnt_q == div);
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: divided SCLK, all CPOL/CPHA modes,
// MSB/LSB ordering, CS framing and start/busy/done handshake.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int N     = 16,
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  spi_shift_engine_if.slave host,
  input  logic              MISO,
  output logic              MOSI,
  output logic              sclk,
  output logic              cs_n
);

  localparam int EW = $clog2(2 * N);
  localparam logic [EW-1:0] LAST = EW'(2 * N - 1);

  spi_state_t       state_q, state_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [N-1:0]     tx_q, tx_d;
  logic [N-1:0]     rx_q, rx_d;
  logic [N-1:0]     dre_q, dre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mosi_q, mosi_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsb_q, lsb_d;
  logic             do_edge;
  logic             tick;

  function automatic logic first_bit(
    logic [N-1:0] w, logic lsb
  );
    return lsb ? w[0] : w[N-1];
  endfunction

  function automatic logic [N-1:0] sh_out(
    logic [N-1:0] w, logic lsb
  );
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [N-1:0] sh_in(
    logic [N-1:0] w, logic lsb, logic b
  );
    return lsb ? {b, w[N-1:1]} : {w[N-2:0], b};
  endfunction

  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .reset(reset),
    .en   (state_q != ST_IDLE),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dre_d   = dre_q;
    div_d   = div_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    do_edge = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sclk_d = host.cpol;
        cs_n_d = 1'b1;
        mosi_d = 1'b1;
        busy_d = 1'b0;
        if (host.start) begin
          state_d = ST_LEAD;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cpol_d  = host.cpol;
          cpha_d  = host.cpha;
          lsb_d   = host.lsb_first;
          div_d   = host.clk_div;
          tx_d    = host.dataSe;
          rx_d    = '0;
          if (!host.cpha) begin
            mosi_d = first_bit(host.dataSe,
                               host.lsb_first);
          end
        end
      end
      ST_LEAD: begin
        if (tick) begin
          state_d = ST_SHIFT;
          edge_d  = '0;
          do_edge = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (edge_q == LAST) begin
            state_d = ST_TRAIL;
          end else begin
            edge_d  = edge_q + 1'b1;
            do_edge = 1'b1;
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          sclk_d  = host.cpol;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b1;
          done_d  = 1'b1;
          dre_d   = rx_q;
        end
      end
    endcase
    // even edge index = leading edge
    if (do_edge) begin
      sclk_d = ~sclk_q;
      if (~edge_d[0] ^ cpha_q) begin
        rx_d = sh_in(rx_q, lsb_q, MISO);
      end
      if (cpha_q && !edge_d[0]) begin
        mosi_d = first_bit(tx_q, lsb_q);
        tx_d   = sh_out(tx_q, lsb_q);
      end
      if (!cpha_q && edge_d[0] &&
          edge_d != LAST) begin
        tx_d   = sh_out(tx_q, lsb_q);
        mosi_d = first_bit(tx_d, lsb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dre_q   <= '0;
      div_q   <= '0;
      mosi_q  <= 1'b1;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dre_q   <= dre_d;
      div_q   <= div_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  assign MOSI        = mosi_q;
  assign sclk        = sclk_q;
  assign cs_n        = cs_n_q;
  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.dataRe = dre_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: table-driven transfers checked by a
// done-time scoreboard, plus start, reset and cpol corner sequences.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;

  typedef struct {
    logic [1:0]    mode;
    logic          lsb;
    logic [DW-1:0] div;
    logic [N-1:0]  tx;
    logic          loop;
    logic [N-1:0]  slv;
    logic [N-1:0]  rx;
    int            lat;
  } vec_t;

  typedef struct {
    logic [N-1:0] data;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic miso, mosi, sclk, cs_n;

  spi_shift_engine_if #(.N(N), .DIV_W(DW)) host ();

  spi_shift_engine #(.N(N), .DIV_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .host (host),
    .MISO (miso),
    .MOSI (mosi),
    .sclk (sclk),
    .cs_n (cs_n)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  vec_t vt[6];
  int total = 0, passed = 0, cyc = 0;
  int sedges = 0, rises = 0;
  int done_cnt = 0, cs_falls = 0;
  logic [N-1:0] slv_word = '0, slv_rx = '0;
  logic slv_lsb = 1'b0, slv_cpha = 1'b0;
  logic loop = 1'b1, slv_bit = 1'b0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1;

  assign miso = loop ? mosi : slv_bit;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // slave model and bus monitor, sampled away from the active edge
  always @(negedge clk) begin
    int idx;
    exp_t e;
    if (cs_n) sedges = 0;
    else if (sclk !== sclk_prev) begin
      sedges++;
      if (sclk) rises++;
      if (((sedges % 2) == 1) != slv_cpha)
        slv_rx = slv_lsb ? {mosi, slv_rx[N-1:1]}
                         : {slv_rx[N-2:0], mosi};
    end
    sclk_prev = sclk;
    if (cs_prev && !cs_n) cs_falls++;
    cs_prev = cs_n;
    if (slv_cpha) idx = (sedges == 0) ? 0 : (sedges - 1) / 2;
    else idx = sedges / 2;
    if (idx > N - 1) idx = N - 1;
    slv_bit = slv_lsb ? slv_word[idx] : slv_word[N-1-idx];
    if (host.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("dataRe", host.dataRe, e.data);
      end
    end
  end

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 2000) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_xfer(input vec_t v);
    int c, d0;
    host.cpol      = v.mode[1];
    host.cpha      = v.mode[0];
    host.lsb_first = v.lsb;
    host.clk_div   = v.div;
    host.dataSe    = v.tx;
    loop     = v.loop;
    slv_word = v.slv;
    slv_lsb  = v.lsb;
    slv_cpha = v.mode[0];
    tick();
    tick();
    chk("idle_sclk", sclk, v.mode[1]);
    rises = 0;
    cs_falls = 0;
    slv_rx = '0;
    d0 = done_cnt;
    c = cyc;
    host.start = 1'b1;
    sb.push_back('{v.rx, c + v.lat});
    tick();
    host.start = 1'b0;
    chk("lead_cs_busy", {cs_n, host.busy}, 2'b01);
    wait_done(d0);
    chk("sclk_rises", rises, N);
    chk("slave_rx", slv_rx, v.tx);
    chk("cs_window", cs_falls, 1);
    chk("done_idle", {cs_n, host.busy, mosi}, 3'b101);
    tick();
    chk("hold", {host.done, host.dataRe}, {1'b0, v.rx});
  endtask

  initial begin
    int c, d0, bad, ex;
    vt[0] = '{SPI_MODE0, 1'b0, 8'd1, 8'hA5,
              1'b1, 8'h00, 8'hA5, 37};
    vt[1] = '{SPI_MODE3, 1'b0, 8'd0, 8'h3C,
              1'b0, 8'hC3, 8'hC3, 19};
    vt[2] = '{SPI_MODE1, 1'b1, 8'd2, 8'h81,
              1'b0, 8'h34, 8'h34, 55};
    vt[3] = '{SPI_MODE2, 1'b1, 8'd3, 8'h5A,
              1'b0, 8'hC6, 8'hC6, 73};
    vt[4] = '{SPI_MODE0, 1'b1, 8'd0, 8'h01,
              1'b0, 8'h80, 8'h80, 19};
    vt[5] = '{SPI_MODE1, 1'b0, 8'd0, 8'hFF,
              1'b1, 8'h00, 8'hFF, 19};
    host.start = 1'b0;
    host.dataSe = '0;
    host.cpol = 1'b0;
    host.cpha = 1'b0;
    host.lsb_first = 1'b0;
    host.clk_div = '0;
    tick();
    tick();
    chk("rst_pins", {mosi, sclk, cs_n}, 3'b101);
    chk("rst_busy", host.busy, 0);
    chk("rst_done", host.done, 0);
    chk("rst_dataRe", host.dataRe, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_xfer(vt[i]);

    // start ignored while busy, then accepted in the done cycle
    host.cpol = 1'b0;
    host.cpha = 1'b0;
    host.lsb_first = 1'b0;
    host.clk_div = 8'd1;
    host.dataSe = 8'hA5;
    loop = 1'b1;
    tick();
    cs_falls = 0;
    d0 = done_cnt;
    c = cyc;
    host.start = 1'b1;
    sb.push_back('{8'hA5, c + 37});
    tick();
    host.start = 1'b0;
    while (done_cnt == d0 && cyc < c + 200) begin
      host.start = (cyc == c + 5) || (cyc == c + 20) ||
                   (cyc >= c + 30);
      if (cyc == c + 30) sb.push_back('{8'hA5, c + 74});
      tick();
    end
    chk("one_done", done_cnt - d0, 1);
    chk("one_cs_window", cs_falls, 1);
    tick();
    host.start = 1'b0;
    chk("b2b_start", {cs_n, host.busy}, 2'b01);
    wait_done(d0 + 1);
    chk("b2b_cs_windows", cs_falls, 2);

    // reset in the middle of a transfer
    host.dataSe = 8'h96;
    tick();
    d0 = done_cnt;
    c = cyc;
    host.start = 1'b1;
    sb.push_back('{8'h96, c + 37});
    tick();
    host.start = 1'b0;
    while (cyc < c + 10) tick();
    reset = 1'b1;
    tick();
    chk("midrst_pins",
        {cs_n, sclk, mosi, host.busy, host.done},
        5'b10100);
    chk("midrst_dataRe", host.dataRe, 0);
    sb.delete();
    reset = 1'b0;
    repeat (60) tick();
    chk("midrst_no_done", done_cnt - d0, 0);
    run_xfer(vt[0]);

    // cpol follows live in IDLE, frozen during a transfer
    host.cpol = 1'b1;
    tick();
    chk("idle_cpol1", sclk, 1);
    host.cpol = 1'b0;
    tick();
    chk("idle_cpol0", sclk, 0);
    host.dataSe = 8'h5A;
    loop = 1'b1;
    tick();
    bad = 0;
    d0 = done_cnt;
    c = cyc;
    host.start = 1'b1;
    sb.push_back('{8'h5A, c + 37});
    tick();
    host.start = 1'b0;
    for (int t = 1; t <= 36; t++) begin
      ex = 0;
      for (int k = 0; k < 2 * N; k++)
        if ((k + 1) * 2 + 1 <= t) ex ^= 1;
      if (sclk !== ex[0]) bad++;
      host.cpol      = 1'($urandom);
      host.cpha      = 1'($urandom);
      host.lsb_first = 1'($urandom);
      host.clk_div   = 8'($urandom);
      host.dataSe    = 8'($urandom);
      tick();
    end
    host.cpol = 1'b0;
    host.cpha = 1'b0;
    host.lsb_first = 1'b0;
    host.clk_div = 8'd1;
    chk("sclk_wave_errs", bad, 0);
    wait_done(d0);

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
